// File: rtl/mem_responder.sv
// Memory-side responder for the core load/store port: one request at a time,
// programmable wait states, byte/half/word access with fault reporting.
module mem_responder #(
   parameter int unsigned DEPTH       = 1024,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        we,
   input  logic [1:0]  size,
   input  logic        uns,
   output logic        busy,
   output logic        ready,
   output logic [31:0] rdata,
   output logic        err
);
   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic [31:0]   a_addr, a_wdata;
   logic          a_we, a_uns;
   logic [1:0]    a_size;
   logic [CW-1:0] cnt;
   logic          accept, access, busy_nxt, ready_nxt;
   logic          misal, oob, fault;
   logic [AW-1:0] widx;
   logic [4:0]    sh;
   logic [31:0]   word, load_val, merged;
   logic [7:0]    lane_b;
   logic [15:0]   lane_h;

   logic [31:0]   mem [DEPTH];

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req) state_nxt = WAIT;
         WAIT:    if (cnt == '0) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode: handshake strobes and next values of busy/ready
   always_comb begin
      accept    = 1'b0;
      access    = 1'b0;
      busy_nxt  = busy;
      ready_nxt = 1'b0;
      case (state)
         IDLE: begin
            accept   = req;
            busy_nxt = req;
         end
         WAIT: begin
            access    = (cnt == '0);
            ready_nxt = (cnt == '0);
            busy_nxt  = 1'b1;
         end
         RESP:    busy_nxt = 1'b0;
         default: busy_nxt = 1'b0;
      endcase
   end

   // Fault detection, lane extraction and store merge on the latched request
   always_comb begin
      widx = a_addr[AW+1:2];
      sh   = 5'({a_addr[1:0], 3'b000});
      case (a_size)
         2'b00:   misal = 1'b0;
         2'b01:   misal = a_addr[0];
         2'b10:   misal = (a_addr[1:0] != 2'b00);
         default: misal = 1'b1;
      endcase
      oob    = ({2'b00, a_addr[31:2]} >= 32'(DEPTH));
      fault  = misal | oob;
      word   = mem[widx];
      lane_b = 8'(word >> sh);
      lane_h = a_addr[1] ? word[31:16] : word[15:0];
      case (a_size)
         2'b00:   load_val = a_uns ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
         2'b01:   load_val = a_uns ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
         default: load_val = word;
      endcase
      case (a_size)
         2'b00:   merged = (word & ~(32'h0000_00FF << sh)) | (32'(a_wdata[7:0]) << sh);
         2'b01:   merged = a_addr[1] ? {a_wdata[15:0], word[15:0]}
                                     : {word[31:16], a_wdata[15:0]};
         default: merged = a_wdata;
      endcase
   end

   // Request latch, wait counter and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         busy    <= 1'b0;
         ready   <= 1'b0;
         err     <= 1'b0;
         rdata   <= '0;
         cnt     <= '0;
         a_addr  <= '0;
         a_wdata <= '0;
         a_we    <= 1'b0;
         a_size  <= 2'b00;
         a_uns   <= 1'b0;
      end else begin
         busy  <= busy_nxt;
         ready <= ready_nxt;
         if (accept) begin
            a_addr  <= addr;
            a_wdata <= wdata;
            a_we    <= we;
            a_size  <= size;
            a_uns   <= uns;
            cnt     <= CW'(WAIT_CYCLES);
         end else if (state == WAIT && cnt != '0) begin
            cnt <= cnt - CW'(1);
         end
         if (access) begin
            err   <= fault;
            rdata <= (fault || a_we) ? '0 : load_val;
         end
      end
   end

   // Array write; the array itself is never reset, and reset drops a pending store
   always_ff @(posedge clk) begin
      if (!rst && access && a_we && !fault) mem[widx] <= merged;
   end
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (2 and 0 wait states) checked against
// a byte-addressed reference memory model.
module tb_mem_responder;
   localparam int unsigned DEPTH = 1024;
   localparam int W2 = 2;
   localparam int W0 = 0;

   logic        clk = 1'b0;
   logic        rst, req2, req0, we, uns;
   logic [31:0] addr, wdata;
   logic [1:0]  size;
   logic        busy2, ready2, err2, busy0, ready0, err0;
   logic [31:0] rdata2, rdata0;

   int tests = 0;
   int fails = 0;

   logic [7:0] bm2 [int unsigned];
   logic [7:0] bm0 [int unsigned];

   always #5 clk = ~clk;

   mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W2)) dut2 (
      .clk(clk), .rst(rst), .req(req2), .addr(addr), .wdata(wdata), .we(we),
      .size(size), .uns(uns), .busy(busy2), .ready(ready2), .rdata(rdata2), .err(err2));

   mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W0)) dut0 (
      .clk(clk), .rst(rst), .req(req0), .addr(addr), .wdata(wdata), .we(we),
      .size(size), .uns(uns), .busy(busy0), .ready(ready0), .rdata(rdata0), .err(err0));

   // Reference: byte-addressed little-endian memory, access rules in plain arithmetic
   function automatic void model(input bit fast, input logic [31:0] a, input logic [31:0] wd,
                                 input logic w, input logic [1:0] sz, input logic u,
                                 output logic [31:0] rd, output logic er);
      int unsigned nb;
      logic [31:0] v;
      nb = 1 << sz;
      er = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0)
           || (a / 4 >= DEPTH);
      rd = '0;
      if (er) return;
      if (w) begin
         for (int i = 0; i < int'(nb); i++) begin
            if (fast) bm0[a + i] = wd[8*i +: 8];
            else      bm2[a + i] = wd[8*i +: 8];
         end
      end else begin
         v = '0;
         for (int i = 0; i < int'(nb); i++)
            v = v | (32'(fast ? bm0[a + i] : bm2[a + i]) << (8 * i));
         if (sz != 2'd2 && !u && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
         rd = v;
      end
   endfunction

   // Issue one request on an idle instance and collect the response
   task automatic drive(input bit fast, input logic [31:0] a, input logic [31:0] wd,
                        input logic w, input logic [1:0] sz, input logic u,
                        output logic [31:0] rd, output logic er, output int lat,
                        output logic busy_mid, output logic after_ready, output logic after_busy);
      @(negedge clk);
      addr = a; wdata = wd; we = w; size = sz; uns = u;
      if (fast) req0 = 1'b1; else req2 = 1'b1;
      @(posedge clk); #1;
      busy_mid = fast ? busy0 : busy2;
      lat = -1;
      for (int n = 1; n <= 40; n++) begin
         if (n > 1 || 1) begin
            @(posedge clk); #1;
         end
         if ((fast ? ready0 : ready2) === 1'b1) begin
            lat = n;
            break;
         end
      end
      rd = fast ? rdata0 : rdata2;
      er = fast ? err0 : err2;
      req0 = 1'b0; req2 = 1'b0;
      @(posedge clk); #1;
      after_ready = fast ? ready0 : ready2;
      after_busy  = fast ? busy0 : busy2;
   endtask

   task automatic prefill(input bit fast);
      logic [31:0] rd, erd, wd;
      logic er, eer, bm, ar, ab;
      int lat;
      for (int i = 0; i < 16; i++) begin
         wd = $urandom;
         model(fast, 32'(4 * i), wd, 1'b1, 2'd2, 1'b0, erd, eer);
         drive(fast, 32'(4 * i), wd, 1'b1, 2'd2, 1'b0, rd, er, lat, bm, ar, ab);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; req2 = 1'b0; req0 = 1'b0;
      addr = '0; wdata = '0; we = 1'b0; size = 2'd0; uns = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests++; if (busy2 !== 1'b0) begin fails++; $display("FAIL reset_busy2 got %b want 0", busy2); end
      tests++; if (ready2 !== 1'b0) begin fails++; $display("FAIL reset_ready2 got %b want 0", ready2); end
      tests++; if (err2 !== 1'b0) begin fails++; $display("FAIL reset_err2 got %b want 0", err2); end
      tests++; if (rdata2 !== 32'h0) begin fails++; $display("FAIL reset_rdata2 got %h want 0", rdata2); end
      tests++; if (busy0 !== 1'b0) begin fails++; $display("FAIL reset_busy0 got %b want 0", busy0); end
      tests++; if (ready0 !== 1'b0) begin fails++; $display("FAIL reset_ready0 got %b want 0", ready0); end
      tests++; if (rdata0 !== 32'h0) begin fails++; $display("FAIL reset_rdata0 got %h want 0", rdata0); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_basic;
      logic [31:0] rd, erd;
      logic er, eer, bm, ar, ab;
      int lat;
      model(1'b0, 32'h10, 32'hDEAD_BEEF, 1'b1, 2'd2, 1'b0, erd, eer);
      drive(1'b0, 32'h10, 32'hDEAD_BEEF, 1'b1, 2'd2, 1'b0, rd, er, lat, bm, ar, ab);
      tests++; if (lat != W2 + 1) begin fails++; $display("FAIL basic_store_latency got %0d want %0d", lat, W2 + 1); end
      tests++; if (bm !== 1'b1) begin fails++; $display("FAIL basic_busy_wait got %b want 1", bm); end
      tests++; if (er !== 1'b0 || rd !== 32'h0) begin fails++; $display("FAIL basic_store_resp got err=%b rdata=%h want 0/0", er, rd); end
      tests++; if (ar !== 1'b0 || ab !== 1'b0) begin fails++; $display("FAIL basic_pulse got ready=%b busy=%b want 0/0", ar, ab); end
      model(1'b0, 32'h10, 32'h0, 1'b0, 2'd2, 1'b0, erd, eer);
      drive(1'b0, 32'h10, 32'h0, 1'b0, 2'd2, 1'b0, rd, er, lat, bm, ar, ab);
      tests++; if (lat != W2 + 1) begin fails++; $display("FAIL basic_load_latency got %0d want %0d", lat, W2 + 1); end
      tests++; if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin fails++; $display("FAIL basic_load got %h err=%b want deadbeef err=0", rd, er); end
   endtask

   task automatic test_lanes;
      logic [31:0] rd, erd;
      logic er, eer, bm, ar, ab;
      int lat;
      model(1'b0, 32'h20, 32'h0, 1'b1, 2'd2, 1'b0, erd, eer);
      drive(1'b0, 32'h20, 32'h0, 1'b1, 2'd2, 1'b0, rd, er, lat, bm, ar, ab);
      model(1'b0, 32'h22, 32'h80, 1'b1, 2'd0, 1'b0, erd, eer);
      drive(1'b0, 32'h22, 32'h80, 1'b1, 2'd0, 1'b0, rd, er, lat, bm, ar, ab);
      drive(1'b0, 32'h22, 32'h0, 1'b0, 2'd0, 1'b0, rd, er, lat, bm, ar, ab);
      tests++; if (rd !== 32'hFFFF_FF80 || er !== 1'b0) begin fails++; $display("FAIL lane_byte_signed got %h err=%b want ffffff80", rd, er); end
      drive(1'b0, 32'h22, 32'h0, 1'b0, 2'd0, 1'b1, rd, er, lat, bm, ar, ab);
      tests++; if (rd !== 32'h0000_0080 || er !== 1'b0) begin fails++; $display("FAIL lane_byte_unsigned got %h err=%b want 00000080", rd, er); end
      // Bytes 0x22=0x80, 0x23=0x00 form half 0x0080, whose sign bit is clear
      drive(1'b0, 32'h22, 32'h0, 1'b0, 2'd1, 1'b0, rd, er, lat, bm, ar, ab);
      tests++; if (rd !== 32'h0000_0080 || er !== 1'b0) begin fails++; $display("FAIL lane_half_signed got %h err=%b want 00000080", rd, er); end
      drive(1'b0, 32'h20, 32'h0, 1'b0, 2'd2, 1'b0, rd, er, lat, bm, ar, ab);
      tests++; if (rd !== 32'h0080_0000) begin fails++; $display("FAIL lane_merge_word got %h want 00800000", rd); end
   endtask

   task automatic test_faults;
      logic [31:0] rd, erd;
      logic er, eer, bm, ar, ab;
      int lat;
      drive(1'b0, 32'h21, 32'h0, 1'b0, 2'd1, 1'b0, rd, er, lat, bm, ar, ab);
      tests++; if (er !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL fault_half_misaligned got err=%b rdata=%h want 1/0", er, rd); end
      drive(1'b0, 32'h26, 32'h1234_5678, 1'b1, 2'd2, 1'b0, rd, er, lat, bm, ar, ab);
      tests++; if (er !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL fault_word_misaligned got err=%b rdata=%h want 1/0", er, rd); end
      drive(1'b0, 32'(DEPTH * 4), 32'h0, 1'b0, 2'd2, 1'b0, rd, er, lat, bm, ar, ab);
      tests++; if (er !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL fault_out_of_range got err=%b rdata=%h want 1/0", er, rd); end
      tests++; if (lat != W2 + 1) begin fails++; $display("FAIL fault_latency got %0d want %0d", lat, W2 + 1); end
      model(1'b0, 32'h24, 32'h0, 1'b0, 2'd2, 1'b0, erd, eer);
      drive(1'b0, 32'h24, 32'h0, 1'b0, 2'd2, 1'b0, rd, er, lat, bm, ar, ab);
      tests++; if (rd !== erd || er !== 1'b0) begin fails++; $display("FAIL fault_no_write got %h err=%b want %h err=0", rd, er, erd); end
   endtask

   // Hold req high throughout; address only matches the intended request on acceptance edges
   task automatic run_stream(input bit fast, input int wc, input int nreq);
      logic [31:0] exps[$];
      logic [31:0] erd, got_rd;
      logic eer, got;
      int period, nready;
      period = wc + 3;
      nready = 0;
      for (int k = 0; k < nreq; k++) begin
         model(fast, 32'(4 * k), 32'h0, 1'b0, 2'd2, 1'b0, erd, eer);
         exps.push_back(erd);
      end
      @(negedge clk);
      we = 1'b0; size = 2'd2; uns = 1'b0;
      if (fast) req0 = 1'b1; else req2 = 1'b1;
      for (int e = 0; e < nreq * period; e++) begin
         if (e % period == 0) addr = 32'(4 * (e / period));
         else                 addr = 32'h20 + 32'(4 * $urandom_range(0, 7));
         @(posedge clk); #1;
         got    = fast ? ready0 : ready2;
         got_rd = fast ? rdata0 : rdata2;
         tests++;
         if (got !== 1'((e % period) == wc + 1)) begin
            fails++;
            $display("FAIL stream_ready_timing edge %0d got %b want %b", e, got, (e % period) == wc + 1);
         end
         if (got === 1'b1) begin
            if (nready < nreq) begin
               tests++;
               if (got_rd !== exps[nready]) begin
                  fails++;
                  $display("FAIL stream_rdata req %0d got %h want %h", nready, got_rd, exps[nready]);
               end
            end
            nready++;
         end
         @(negedge clk);
      end
      req0 = 1'b0; req2 = 1'b0;
      tests++; if (nready != nreq) begin fails++; $display("FAIL stream_ready_count got %0d want %0d", nready, nreq); end
      @(posedge clk);
   endtask

   task automatic test_busy;
      run_stream(1'b0, W2, 3);
   endtask

   task automatic test_back_to_back;
      run_stream(1'b1, W0, 4);
   endtask

   task automatic test_reset_mid;
      logic [31:0] rd, erd;
      logic er, eer, bm, ar, ab;
      int lat;
      @(negedge clk);
      addr = 32'h30; wdata = 32'hCAFE_F00D; we = 1'b1; size = 2'd2; uns = 1'b0; req2 = 1'b1;
      @(posedge clk); #1;
      req2 = 1'b0;
      tests++; if (busy2 !== 1'b1) begin fails++; $display("FAIL rstmid_busy_before got %b want 1", busy2); end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      tests++; if (busy2 !== 1'b0 || ready2 !== 1'b0 || err2 !== 1'b0) begin
         fails++; $display("FAIL rstmid_outputs got busy=%b ready=%b err=%b want 0/0/0", busy2, ready2, err2);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      tests++; if (ready2 !== 1'b0 || busy2 !== 1'b0) begin fails++; $display("FAIL rstmid_stays_idle got ready=%b busy=%b want 0/0", ready2, busy2); end
      model(1'b0, 32'h30, 32'h0, 1'b0, 2'd2, 1'b0, erd, eer);
      drive(1'b0, 32'h30, 32'h0, 1'b0, 2'd2, 1'b0, rd, er, lat, bm, ar, ab);
      tests++; if (rd !== erd || er !== 1'b0) begin fails++; $display("FAIL rstmid_store_dropped got %h want %h", rd, erd); end
   endtask

   task automatic test_random(input bit fast, input int wc, input int n);
      logic [31:0] a, wd, rd, erd;
      logic [1:0] sz;
      logic w, u, er, eer, bm, ar, ab;
      int lat, r;
      for (int k = 0; k < n; k++) begin
         r  = int'($urandom_range(0, 9));
         if (r == 0)      a = 32'(DEPTH * 4) + 32'($urandom_range(0, 7));
         else if (r == 1) a = $urandom | 32'h8000_0000;
         else             a = 32'($urandom_range(0, 63));
         sz = (r == 2) ? 2'd3 : 2'($urandom_range(0, 2));
         w  = 1'($urandom_range(0, 1));
         u  = 1'($urandom_range(0, 1));
         wd = $urandom;
         model(fast, a, wd, w, sz, u, erd, eer);
         drive(fast, a, wd, w, sz, u, rd, er, lat, bm, ar, ab);
         tests++; if (rd !== erd) begin fails++; $display("FAIL rand_rdata a=%h sz=%0d we=%b uns=%b got %h want %h", a, sz, w, u, rd, erd); end
         tests++; if (er !== eer) begin fails++; $display("FAIL rand_err a=%h sz=%0d got %b want %b", a, sz, er, eer); end
         tests++; if (lat != wc + 1) begin fails++; $display("FAIL rand_latency got %0d want %0d", lat, wc + 1); end
         tests++; if (ar !== 1'b0) begin fails++; $display("FAIL rand_pulse_width ready after RESP got %b want 0", ar); end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset;
      prefill(1'b0);
      prefill(1'b1);
      test_basic;
      test_lanes;
      test_faults;
      test_busy;
      test_reset_mid;
      test_back_to_back;
      test_random(1'b0, W2, 40);
      test_random(1'b1, W0, 40);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
